// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// Produces pixel/line counters, the visible-area flag, hsync/vsync with
// configurable polarity, and per-line / per-frame strobes. Every output is
// registered and the decodes are computed from the next counter values, so
// counters and decodes always describe the same raster position.
module vga_sync_gen #(
   parameter int H_VIS  = 800,
   parameter int H_FP   = 56,
   parameter int H_SYNC = 120,
   parameter int H_BP   = 64,
   parameter int V_VIS  = 600,
   parameter int V_FP   = 37,
   parameter int V_SYNC = 6,
   parameter int V_BP   = 23,
   parameter int HS_POL = 1,
   parameter int VS_POL = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic [11:0] hcounter,
   output logic [10:0] vcounter,
   output logic        visible,
   output logic        hsync,
   output logic        vsync,
   output logic        line_tick,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   // Sync window bounds (start inclusive, end exclusive).
   localparam int H_SS = H_VIS + H_FP;
   localparam int H_SE = H_VIS + H_FP + H_SYNC;
   localparam int V_SS = V_VIS + V_FP;
   localparam int V_SE = V_VIS + V_FP + V_SYNC;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

   localparam logic HS_ACT = (HS_POL != 0) ? 1'b1 : 1'b0;
   localparam logic VS_ACT = (VS_POL != 0) ? 1'b1 : 1'b0;

   // The counters are 12 and 11 bits wide; larger rasters cannot be represented.
   if (H_TOTAL > 4096 || H_TOTAL < 1) begin : g_bad_h_total
      $error("vga_sync_gen: H_TOTAL=%0d outside 1..4096", H_TOTAL);
   end
   if (V_TOTAL > 2048 || V_TOTAL < 1) begin : g_bad_v_total
      $error("vga_sync_gen: V_TOTAL=%0d outside 1..2048", V_TOTAL);
   end

   logic [11:0] h_q, h_d, h_nxt;
   logic [10:0] v_q, v_d, v_nxt;
   logic        vis_q, vis_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        lt_q, lt_d;
   logic        ft_q, ft_d;
   logic        h_wrap;

   // Next raster position and the registered decodes that go with it.
   always_comb begin
      // ">=" rather than "==" so any out-of-range value wraps on the next advance.
      h_wrap = (h_q >= H_LAST);
      h_nxt  = h_wrap ? 12'd0 : h_q + 12'd1;
      v_nxt  = v_q;
      if (h_wrap) begin
         v_nxt = (v_q >= V_LAST) ? 11'd0 : v_q + 11'd1;
      end

      h_d   = h_q;
      v_d   = v_q;
      vis_d = vis_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      lt_d  = 1'b0;
      ft_d  = 1'b0;

      if (pix_en) begin
         h_d   = h_nxt;
         v_d   = v_nxt;
         vis_d = (int'(h_nxt) < H_VIS) && (int'(v_nxt) < V_VIS);
         hs_d  = ((int'(h_nxt) >= H_SS) && (int'(h_nxt) < H_SE)) ? HS_ACT : ~HS_ACT;
         vs_d  = ((int'(v_nxt) >= V_SS) && (int'(v_nxt) < V_SE)) ? VS_ACT : ~VS_ACT;
         lt_d  = h_wrap;
         ft_d  = h_wrap && (int'(v_nxt) == V_VIS);
      end
   end

   // State registers; reset parks the raster at (0,0) with syncs inactive.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q   <= 12'd0;
         v_q   <= 11'd0;
         vis_q <= 1'b0;
         hs_q  <= ~HS_ACT;
         vs_q  <= ~VS_ACT;
         lt_q  <= 1'b0;
         ft_q  <= 1'b0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         vis_q <= vis_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         lt_q  <= lt_d;
         ft_q  <= ft_d;
      end
   end

   assign hcounter   = h_q;
   assign vcounter   = v_q;
   assign visible    = vis_q;
   assign hsync      = hs_q;
   assign vsync      = vs_q;
   assign line_tick  = lt_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: one default-mode instance plus two small-raster
// instances (positive and negative sync polarity) sharing clock, reset and
// pix_en, checked against a position-index reference model.
`timescale 1ns/1ps
module tb_vga_sync_gen;

   localparam int HV_A  [3] = '{800, 10, 10};
   localparam int HFP_A [3] = '{56,  3,  3};
   localparam int HSW_A [3] = '{120, 4,  4};
   localparam int HBP_A [3] = '{64,  5,  5};
   localparam int VV_A  [3] = '{600, 6,  6};
   localparam int VFP_A [3] = '{37,  2,  2};
   localparam int VSW_A [3] = '{6,   3,  3};
   localparam int VBP_A [3] = '{23,  2,  2};
   localparam bit HP_A  [3] = '{1'b1, 1'b1, 1'b0};
   localparam bit VP_A  [3] = '{1'b1, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en = 1'b0;
   logic [11:0] hc  [3];
   logic [10:0] vc  [3];
   logic        vis [3];
   logic        hsy [3];
   logic        vsy [3];
   logic        ltk [3];
   logic        ftk [3];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_sync_gen u_dut0 (
      .clk(clk), .reset(rst), .pix_en(pix_en),
      .hcounter(hc[0]), .vcounter(vc[0]), .visible(vis[0]),
      .hsync(hsy[0]), .vsync(vsy[0]), .line_tick(ltk[0]), .frame_tick(ftk[0])
   );

   vga_sync_gen #(
      .H_VIS(10), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_VIS(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
      .HS_POL(1), .VS_POL(1)
   ) u_dut1 (
      .clk(clk), .reset(rst), .pix_en(pix_en),
      .hcounter(hc[1]), .vcounter(vc[1]), .visible(vis[1]),
      .hsync(hsy[1]), .vsync(vsy[1]), .line_tick(ltk[1]), .frame_tick(ftk[1])
   );

   vga_sync_gen #(
      .H_VIS(10), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_VIS(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
      .HS_POL(0), .VS_POL(0)
   ) u_dut2 (
      .clk(clk), .reset(rst), .pix_en(pix_en),
      .hcounter(hc[2]), .vcounter(vc[2]), .visible(vis[2]),
      .hsync(hsy[2]), .vsync(vsy[2]), .line_tick(ltk[2]), .frame_tick(ftk[2])
   );

   function automatic int ht(int i);
      return HV_A[i] + HFP_A[i] + HSW_A[i] + HBP_A[i];
   endfunction

   function automatic int vt(int i);
      return VV_A[i] + VFP_A[i] + VSW_A[i] + VBP_A[i];
   endfunction

   // Reference model: the raster position is a single index into the frame.
   int m_pos [3];
   bit m_vis [3];
   bit m_hs  [3];
   bit m_vs  [3];
   bit m_lt  [3];
   bit m_ft  [3];

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_pos[i] <= 0;
            m_vis[i] <= 1'b0;
            m_hs[i]  <= !HP_A[i];
            m_vs[i]  <= !VP_A[i];
            m_lt[i]  <= 1'b0;
            m_ft[i]  <= 1'b0;
         end else if (pix_en) begin
            int np, h, v;
            np = (m_pos[i] + 1) % (ht(i) * vt(i));
            h  = np % ht(i);
            v  = np / ht(i);
            m_pos[i] <= np;
            m_vis[i] <= (h < HV_A[i]) && (v < VV_A[i]);
            m_hs[i]  <= (h >= HV_A[i] + HFP_A[i] && h < HV_A[i] + HFP_A[i] + HSW_A[i]) ? HP_A[i] : !HP_A[i];
            m_vs[i]  <= (v >= VV_A[i] + VFP_A[i] && v < VV_A[i] + VFP_A[i] + VSW_A[i]) ? VP_A[i] : !VP_A[i];
            m_lt[i]  <= (h == 0);
            m_ft[i]  <= (h == 0) && (v == VV_A[i]);
         end else begin
            m_lt[i] <= 1'b0;
            m_ft[i] <= 1'b0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pix_en = 1'b1;
      repeat (3) cyc();
      for (int i = 0; i < 3; i++) begin
         checks += 7;
         if (hc[i] !== 12'd0) begin failures++; $display("FAIL reset_h dut%0d: got %0d expected 0", i, hc[i]); end
         if (vc[i] !== 11'd0) begin failures++; $display("FAIL reset_v dut%0d: got %0d expected 0", i, vc[i]); end
         if (vis[i] !== 1'b0) begin failures++; $display("FAIL reset_vis dut%0d: got %b expected 0", i, vis[i]); end
         if (hsy[i] !== !HP_A[i]) begin failures++; $display("FAIL reset_hsync dut%0d: got %b expected %b", i, hsy[i], !HP_A[i]); end
         if (vsy[i] !== !VP_A[i]) begin failures++; $display("FAIL reset_vsync dut%0d: got %b expected %b", i, vsy[i], !VP_A[i]); end
         if (ltk[i] !== 1'b0) begin failures++; $display("FAIL reset_lt dut%0d: got %b expected 0", i, ltk[i]); end
         if (ftk[i] !== 1'b0) begin failures++; $display("FAIL reset_ft dut%0d: got %b expected 0", i, ftk[i]); end
      end
   endtask

   task automatic test_first_cycle();
      rst = 1'b0;
      pix_en = 1'b1;
      cyc();
      checks += 6;
      if (hc[0] !== 12'd1) begin failures++; $display("FAIL first_h: got %0d expected 1", hc[0]); end
      if (vc[0] !== 11'd0) begin failures++; $display("FAIL first_v: got %0d expected 0", vc[0]); end
      if (vis[0] !== 1'b1) begin failures++; $display("FAIL first_vis: got %b expected 1", vis[0]); end
      if (hsy[0] !== 1'b0) begin failures++; $display("FAIL first_hsync: got %b expected 0", hsy[0]); end
      if (ltk[0] !== 1'b0) begin failures++; $display("FAIL first_lt: got %b expected 0", ltk[0]); end
      if (ftk[0] !== 1'b0) begin failures++; $display("FAIL first_ft: got %b expected 0", ftk[0]); end
   endtask

   task automatic test_line();
      int hs_cnt = 0, hs_first = -1, hs_last = -1, lt_cnt = 0;
      for (int k = 0; k < 1039; k++) begin
         cyc();
         if (hsy[0]) begin
            if (hs_first < 0) hs_first = int'(hc[0]);
            hs_last = int'(hc[0]);
            hs_cnt++;
         end
         if (ltk[0]) lt_cnt++;
      end
      checks += 7;
      if (hc[0] !== 12'd0) begin failures++; $display("FAIL line_wrap_h: got %0d expected 0", hc[0]); end
      if (vc[0] !== 11'd1) begin failures++; $display("FAIL line_wrap_v: got %0d expected 1", vc[0]); end
      if (ltk[0] !== 1'b1) begin failures++; $display("FAIL line_tick_at_wrap: got %b expected 1", ltk[0]); end
      if (lt_cnt != 1) begin failures++; $display("FAIL line_tick_count: got %0d expected 1", lt_cnt); end
      if (hs_cnt != 120) begin failures++; $display("FAIL hsync_width: got %0d expected 120", hs_cnt); end
      if (hs_first != 856) begin failures++; $display("FAIL hsync_start: got %0d expected 856", hs_first); end
      if (hs_last != 975) begin failures++; $display("FAIL hsync_end: got %0d expected 975", hs_last); end
      lt_cnt = 0;
      for (int k = 0; k < 1040; k++) begin
         cyc();
         if (ltk[0]) lt_cnt++;
      end
      checks += 4;
      if (hc[0] !== 12'd0) begin failures++; $display("FAIL period_h: got %0d expected 0", hc[0]); end
      if (vc[0] !== 11'd2) begin failures++; $display("FAIL period_v: got %0d expected 2", vc[0]); end
      if (ltk[0] !== 1'b1) begin failures++; $display("FAIL period_lt: got %b expected 1", ltk[0]); end
      if (lt_cnt != 1) begin failures++; $display("FAIL period_lt_count: got %0d expected 1", lt_cnt); end
   endtask

   task automatic test_half_rate();
      int lt_cnt = 0;
      logic [11:0] ph;
      logic [10:0] pv;
      logic pvis, phs, pvs;
      for (int k = 0; k < 2079; k++) begin
         pix_en = (k % 2 == 0);
         ph = hc[0]; pv = vc[0]; pvis = vis[0]; phs = hsy[0]; pvs = vsy[0];
         cyc();
         if (ltk[0]) lt_cnt++;
         if (!pix_en) begin
            checks += 7;
            if (hc[0] !== ph) begin failures++; $display("FAIL hold_h: got %0d expected %0d", hc[0], ph); end
            if (vc[0] !== pv) begin failures++; $display("FAIL hold_v: got %0d expected %0d", vc[0], pv); end
            if (vis[0] !== pvis) begin failures++; $display("FAIL hold_vis: got %b expected %b", vis[0], pvis); end
            if (hsy[0] !== phs) begin failures++; $display("FAIL hold_hsync: got %b expected %b", hsy[0], phs); end
            if (vsy[0] !== pvs) begin failures++; $display("FAIL hold_vsync: got %b expected %b", vsy[0], pvs); end
            if (ltk[0] !== 1'b0) begin failures++; $display("FAIL hold_lt: got %b expected 0", ltk[0]); end
            if (ftk[0] !== 1'b0) begin failures++; $display("FAIL hold_ft: got %b expected 0", ftk[0]); end
         end
      end
      checks += 4;
      if (hc[0] !== 12'd0) begin failures++; $display("FAIL half_h: got %0d expected 0", hc[0]); end
      if (vc[0] !== 11'd3) begin failures++; $display("FAIL half_v: got %0d expected 3", vc[0]); end
      if (ltk[0] !== 1'b1) begin failures++; $display("FAIL half_lt: got %b expected 1", ltk[0]); end
      if (lt_cnt != 1) begin failures++; $display("FAIL half_lt_count: got %0d expected 1", lt_cnt); end
      pix_en = 1'b1;
   endtask

   task automatic test_mid_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      pix_en = 1'b1;
      repeat (500) cyc();
      checks += 1;
      if (hc[0] !== 12'd500) begin failures++; $display("FAIL pre_reset_h: got %0d expected 500", hc[0]); end
      rst = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         checks += 5;
         if (hc[i] !== 12'd0) begin failures++; $display("FAIL midrst_h dut%0d: got %0d expected 0", i, hc[i]); end
         if (vc[i] !== 11'd0) begin failures++; $display("FAIL midrst_v dut%0d: got %0d expected 0", i, vc[i]); end
         if (vis[i] !== 1'b0) begin failures++; $display("FAIL midrst_vis dut%0d: got %b expected 0", i, vis[i]); end
         if (hsy[i] !== !HP_A[i]) begin failures++; $display("FAIL midrst_hsync dut%0d: got %b expected %b", i, hsy[i], !HP_A[i]); end
         if (vsy[i] !== !VP_A[i]) begin failures++; $display("FAIL midrst_vsync dut%0d: got %b expected %b", i, vsy[i], !VP_A[i]); end
      end
      rst = 1'b0;
      cyc();
      checks += 2;
      if (hc[0] !== 12'd1) begin failures++; $display("FAIL restart_h: got %0d expected 1", hc[0]); end
      if (vc[0] !== 11'd0) begin failures++; $display("FAIL restart_v: got %0d expected 0", vc[0]); end
   endtask

   // Two full frames of the small raster: 22 x 13 = 286 cycles each.
   task automatic test_frame();
      int ft_cnt = 0, ft_first = -1, ft_second = -1, ft_bad_pos = 0;
      int vis_cnt = 0, vs_cnt = 0, lt_cnt = 0, hs2_low = 0, vs2_low = 0;
      for (int k = 0; k < 572; k++) begin
         cyc();
         if (ftk[1]) begin
            ft_cnt++;
            if (ft_first < 0) ft_first = k; else ft_second = k;
            if (hc[1] !== 12'd0 || vc[1] !== 11'd6) ft_bad_pos++;
         end
         if (vis[1]) vis_cnt++;
         if (vsy[1]) vs_cnt++;
         if (ltk[1]) lt_cnt++;
         if (!hsy[2]) hs2_low++;
         if (!vsy[2]) vs2_low++;
      end
      checks += 8;
      if (ft_cnt != 2) begin failures++; $display("FAIL frame_tick_count: got %0d expected 2", ft_cnt); end
      if (ft_second - ft_first != 286) begin failures++; $display("FAIL frame_period: got %0d expected 286", ft_second - ft_first); end
      if (ft_bad_pos != 0) begin failures++; $display("FAIL frame_tick_pos: got %0d bad expected 0", ft_bad_pos); end
      if (vis_cnt != 120) begin failures++; $display("FAIL visible_count: got %0d expected 120", vis_cnt); end
      if (vs_cnt != 132) begin failures++; $display("FAIL vsync_count: got %0d expected 132", vs_cnt); end
      if (lt_cnt != 26) begin failures++; $display("FAIL line_ticks_frame: got %0d expected 26", lt_cnt); end
      if (hs2_low != 104) begin failures++; $display("FAIL neg_hsync_low: got %0d expected 104", hs2_low); end
      if (vs2_low != 132) begin failures++; $display("FAIL neg_vsync_low: got %0d expected 132", vs2_low); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 6000; k++) begin
         pix_en = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 399) == 0);
         cyc();
         for (int i = 0; i < 3; i++) begin
            checks += 7;
            if (int'(hc[i]) !== m_pos[i] % ht(i)) begin failures++; $display("FAIL rand_h dut%0d: got %0d expected %0d", i, hc[i], m_pos[i] % ht(i)); end
            if (int'(vc[i]) !== m_pos[i] / ht(i)) begin failures++; $display("FAIL rand_v dut%0d: got %0d expected %0d", i, vc[i], m_pos[i] / ht(i)); end
            if (vis[i] !== m_vis[i]) begin failures++; $display("FAIL rand_vis dut%0d: got %b expected %b", i, vis[i], m_vis[i]); end
            if (hsy[i] !== m_hs[i]) begin failures++; $display("FAIL rand_hsync dut%0d: got %b expected %b", i, hsy[i], m_hs[i]); end
            if (vsy[i] !== m_vs[i]) begin failures++; $display("FAIL rand_vsync dut%0d: got %b expected %b", i, vsy[i], m_vs[i]); end
            if (ltk[i] !== m_lt[i]) begin failures++; $display("FAIL rand_lt dut%0d: got %b expected %b", i, ltk[i], m_lt[i]); end
            if (ftk[i] !== m_ft[i]) begin failures++; $display("FAIL rand_ft dut%0d: got %b expected %b", i, ftk[i], m_ft[i]); end
         end
      end
      rst = 1'b0;
      pix_en = 1'b1;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_cycle();
      test_line();
      test_half_rate();
      test_mid_reset();
      test_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA raster timing: `hcounter`, `vcounter` and `visible` for the pixel renderers (ball/sprite drawers), plus `hsync`/`vsync` for the DAC connector.
- Also emits `line_tick` and `frame_tick` strobes so game logic (ball position update) can run once per frame during vertical blank.
- Sits between the board clock and every combinational pixel-drawing block.

Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_VIS, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level

Ports:
- clk  input  1  system clock (50 MHz for the default 800x600@72 mode)
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel-advance enable; tie high when clk is the pixel clock
- hcounter  output  12  current pixel column, 0..H_TOTAL-1
- vcounter  output  11  current line, 0..V_TOTAL-1
- visible  output  1  high when hcounter < H_VIS and vcounter < V_VIS
- hsync  output  1  horizontal sync, level set by HS_POL
- vsync  output  1  vertical sync, level set by VS_POL
- line_tick  output  1  one-cycle pulse at the start of each line
- frame_tick  output  1  one-cycle pulse at the start of vertical blank

Behaviour:
- Derived constants:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (default 1040).
  - V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (default 666).
- Reset (sampled on the clk rising edge while reset=1):
  - hcounter=0, vcounter=0.
  - visible=0, line_tick=0, frame_tick=0.
  - hsync=~HS_POL, vsync=~VS_POL (both inactive).
  - Reset dominates pix_en.
  - Reset asserted mid-line or mid-frame returns everything to these values on the next edge; no partial line is completed.
- Counting (all outputs registered; no combinational path from inputs to outputs):
  - If pix_en=1: hcounter <= hcounter+1, wrapping from H_TOTAL-1 to 0.
  - On that wrap, vcounter <= vcounter+1, wrapping from V_TOTAL-1 to 0.
  - If pix_en=0: counters, visible, hsync and vsync hold their values, and both ticks are 0.
- Decode: `visible`, `hsync` and `vsync` are computed from the next counter values and registered, so in any cycle they describe the same (hcounter, vcounter) pair currently on the outputs. There is zero relative latency between counters and decodes.
  - visible = (h < H_VIS) && (v < V_VIS). The only exception is the reset cycle itself, where visible is forced to 0.
  - hsync is active for H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (default 856..975), else inactive.
  - vsync is active for V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (default 637..642), else inactive.
- Ticks (registered, single clk cycle wide, only in cycles where pix_en=1):
  - line_tick=1 in the cycle where hcounter becomes 0.
  - frame_tick=1 in the cycle where hcounter becomes 0 and vcounter becomes V_VIS.
  - The first cycle after reset release produces no ticks.
- Arithmetic: the counter compare at H_TOTAL-1 / V_TOTAL-1 must be exact. Counters never exceed TOTAL-1; an out-of-range value is treated as the wrap point, returning to 0 on the next advance.
- Width rule: H_TOTAL must be <= 4096 and V_TOTAL <= 2048. This is checked by an elaboration-time assertion.

Test Plan:
- Reset, then release with pix_en=1 -> cycle 1 has hcounter=1, vcounter=0, visible=1, hsync inactive, no ticks.
- Run one line -> hsync active exactly for hcounter 856..975 (120 cycles); hcounter wraps 1039->0, vcounter 0->1, line_tick pulses once; line period 1040 cycles.
- Run a full frame -> vsync active only for vcounter 637..642 (6 lines); frame_tick pulses once, with hcounter=0 and vcounter=600; frame period 1040*666 = 692640 cycles; visible high for 800*600 = 480000 cycles per frame.
- pix_en toggled 1,0,1,0 (half rate) -> counters advance every other cycle; outputs hold on pix_en=0 cycles; no ticks on those cycles; line period 2080 cycles.
- Reset asserted at hcounter=500, vcounter=300 -> next edge gives all outputs at reset values; count restarts from (0,0).
- Parameters HS_POL=0, VS_POL=0 -> hsync/vsync idle high and low only in the sync windows; counter timing is unchanged.
